instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch stage and cycle sequencer of the multicycle MIPS core.
- Takes the current PC address and issues an instruction read on the Avalon-style memory bus, honouring waitrequest.
- Latches the returned word into the instruction register and slices it into fields.
- Generates the one-hot cycle_1/cycle_2 strobes that the PC and execute logic consume; detects halt and parks the core.

Parameters:
- SWAP_BYTES, 1, when 1 the instruction register stores readdata byte-reversed ({b0,b1,b2,b3}); when 0 it stores readdata unchanged.
- RESET_VECTOR, 32'hBFC00000, expected PC after reset; used only by the bench and assertions, not by RTL datapath.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pc_address  in  32  current PC value.
- halt  in  1  PC halt flag (PC has reached address 0).
- exec_stall  in  1  execute/data-memory side is not ready to leave cycle_1.
- mem_address  out  32  instruction read address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  bus not ready; the request must be held.
- mem_readdata  in  32  read data, valid in the cycle waitrequest=0 with read=1.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- branch_param  out  5  instr[20:16] (rt / REGIMM selector).
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- offset  out  16  instr[15:0].
- instr_index  out  26  instr[25:0].
- cycle_1  out  1  first execute cycle strobe.
- cycle_2  out  1  second execute cycle strobe; the PC updates on this.
- active  out  1  core running (low once halted).

Behaviour:
- States: FETCH, EXEC1, EXEC2, HALTED. The state register is the only control storage.
- Reset (synchronous, any state, including mid-read):
  - state=FETCH, instr=0, active=1.
  - mem_read=0 and cycle_1=cycle_2=0 during the reset cycle.
  - An abandoned read is not resumed; the first post-reset cycle issues a fresh read.
- FETCH:
  - mem_read=1, mem_address=pc_address (combinational).
  - While mem_waitrequest=1: stay in FETCH; mem_address and mem_read are held stable. pc_address does not change, because the PC only moves on cycle_2.
  - When mem_waitrequest=0: capture mem_readdata (swapped per SWAP_BYTES) into instr at that edge and go to EXEC1.
  - Minimum fetch latency is 1 cycle.
- EXEC1:
  - cycle_1=1, mem_read=0.
  - If exec_stall=1, stay in EXEC1 with cycle_1 held high. The PC holding its address on cycle_1 makes repeats harmless.
  - Otherwise go to EXEC2.
- EXEC2:
  - cycle_2=1 for exactly one cycle, mem_read=0. exec_stall is ignored, since a repeated cycle_2 would double-advance the PC.
  - Next state: HALTED if halt=1 in this cycle, else FETCH.
- HALTED:
  - mem_read=0, cycle_1=cycle_2=0, active=0. instr retains its last value.
  - Exits only via reset.
- Field outputs are combinational slices of instr. Overlapping slices (offset/rd/shamt/funct, instr_index/rs) are intentional.
- cycle_1 and cycle_2 are never high together and never high in FETCH or HALTED.
- mem_read is never high outside FETCH.
- instr changes only on an accepted read edge or on reset.
- Simultaneous events:
  - reset has priority over everything.
  - halt asserted outside EXEC2 is ignored until the EXEC2 exit.
  - waitrequest dropping in the same cycle as reset is discarded.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum.
  - Opcode enum (SPECIAL, REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ) and REGIMM enum (BLTZ, BGEZ, BLTZAL=16, BGEZAL), shared with the PC and decoder.
  - Field width constants.
  - RESET_VECTOR.
- No sub-module. Byte swap and field slicing are inline; one FSM always_ff plus one always_comb output block.

Test Plan:
- Reset then mem_waitrequest=0, pc_address=BFC00000, readdata=0x0C00_0010 with SWAP_BYTES=0 -> mem_read=1 in cycle 1, addr BFC00000; instr=0x0C000010, opcode=3, instr_index=0x10; cycle_1 next cycle, then cycle_2, then FETCH.
- waitrequest=1 for 3 cycles then 0, readdata=0x78563412, SWAP_BYTES=1 -> mem_read/mem_address stable for 4 cycles; instr=0x12345678 captured only on the 4th edge; no strobes before it.
- exec_stall=1 for 2 cycles in EXEC1 -> cycle_1 high 3 cycles, then cycle_2 high exactly 1 cycle, even with exec_stall=1 in EXEC2.
- halt=1 during EXEC2 -> HALTED next cycle: active=0, mem_read=0, no strobes for 10+ cycles; reset -> FETCH with active=1.
- reset pulsed while in FETCH with waitrequest=1 -> mem_read=0 in reset cycle, instr=0, new read issued next cycle; late readdata during reset is not captured.
- halt=1 during FETCH/EXEC1 only (low in EXEC2) -> no halt; a normal FETCH follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: fetch FSM states,
// opcode/REGIMM encodings, instruction field widths and the reset vector.
package cpu_pkg;

  // Fetch/sequencer states
  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StExec1  = 2'd1,
    StExec2  = 2'd2,
    StHalted = 2'd3
  } fetch_state_e;

  // Primary opcodes consumed by the PC and decoder
  typedef enum logic [5:0] {
    OpSpecial = 6'h00,
    OpRegimm  = 6'h01,
    OpJ       = 6'h02,
    OpJal     = 6'h03,
    OpBeq     = 6'h04,
    OpBne     = 6'h05,
    OpBlez    = 6'h06,
    OpBgtz    = 6'h07
  } opcode_e;

  // REGIMM selectors carried in the rt field
  typedef enum logic [4:0] {
    RiBltz   = 5'd0,
    RiBgez   = 5'd1,
    RiBltzal = 5'd16,
    RiBgezal = 5'd17
  } regimm_e;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned INDEX_W  = 26;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // Reverse byte order of a 32-bit word
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch stage and cycle sequencer: issues the instruction read, latches the
// instruction register, and walks FETCH -> EXEC1 -> EXEC2 until halted.
module instr_fetch_ctrl #(
  parameter bit          SWAP_BYTES   = 1'b1,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  input  logic        halt,
  input  logic        exec_stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  branch_param,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] offset,
  output logic [25:0] instr_index,
  output logic        cycle_1,
  output logic        cycle_2,
  output logic        active
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q;
  logic [31:0]  fetch_word;
  logic         read_accept;

  // PC is stable throughout FETCH, so the address can pass straight through
  assign mem_address = pc_address;
  assign fetch_word  = SWAP_BYTES ? byte_swap(mem_readdata) : mem_readdata;
  assign read_accept = (state_q == StFetch) && !mem_waitrequest && !reset;

  // State register and instruction register; reset discards any in-flight read
  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (reset) begin
      instr_q <= '0;
    end else if (read_accept) begin
      instr_q <= fetch_word;
    end
  end

  // Next-state and strobe decode; reset forces everything quiet this cycle
  always_comb begin
    state_d  = state_q;
    mem_read = 1'b0;
    cycle_1  = 1'b0;
    cycle_2  = 1'b0;
    active   = 1'b1;
    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_d = StExec1;
      end
      StExec1: begin
        cycle_1 = 1'b1;
        if (!exec_stall) state_d = StExec2;
      end
      StExec2: begin
        // Stall ignored here: a repeated cycle_2 would advance the PC twice
        cycle_2 = 1'b1;
        state_d = halt ? StHalted : StFetch;
      end
      StHalted: begin
        active = 1'b0;
      end
      default: state_d = StFetch;
    endcase
    if (reset) begin
      state_d  = StFetch;
      mem_read = 1'b0;
      cycle_1  = 1'b0;
      cycle_2  = 1'b0;
      active   = 1'b1;
    end
  end

  assign instr        = instr_q;
  assign opcode       = instr_q[31 -: OPCODE_W];
  assign rs           = instr_q[25 -: REG_W];
  assign branch_param = instr_q[20 -: REG_W];
  assign rd           = instr_q[15 -: REG_W];
  assign shamt        = instr_q[10 -: SHAMT_W];
  assign funct        = instr_q[FUNCT_W-1:0];
  assign offset       = instr_q[OFFSET_W-1:0];
  assign instr_index  = instr_q[INDEX_W-1:0];

  // The first fetch after reset must target the reset vector
  first_fetch_at_vector: assert property (@(posedge clk) $fell(reset) |-> pc_address == RESET_VECTOR);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then randomized traffic,
// all checked per cycle against a phase-level reference model.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_address = RV;
  logic        halt = 1'b0;
  logic        exec_stall = 1'b0;
  logic        mem_waitrequest = 1'b1;
  logic [31:0] mem_readdata = '0;

  logic [31:0] mem_address, instr;
  logic        mem_read, cycle_1, cycle_2, active;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, branch_param, rd, shamt;
  logic [15:0] offset;
  logic [25:0] instr_index;

  logic [31:0] d0_mem_address, d0_instr;
  logic        d0_mem_read, d0_cycle_1, d0_cycle_2, d0_active;
  logic [5:0]  d0_opcode, d0_funct;
  logic [4:0]  d0_rs, d0_branch_param, d0_rd, d0_shamt;
  logic [15:0] d0_offset;
  logic [25:0] d0_instr_index;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.SWAP_BYTES(1'b1), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .pc_address(pc_address), .halt(halt), .exec_stall(exec_stall),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .instr(instr), .opcode(opcode), .rs(rs),
    .branch_param(branch_param), .rd(rd), .shamt(shamt), .funct(funct), .offset(offset),
    .instr_index(instr_index), .cycle_1(cycle_1), .cycle_2(cycle_2), .active(active)
  );

  instr_fetch_ctrl #(.SWAP_BYTES(1'b0), .RESET_VECTOR(RV)) dut0 (
    .clk(clk), .reset(reset), .pc_address(pc_address), .halt(halt), .exec_stall(exec_stall),
    .mem_address(d0_mem_address), .mem_read(d0_mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .instr(d0_instr), .opcode(d0_opcode), .rs(d0_rs),
    .branch_param(d0_branch_param), .rd(d0_rd), .shamt(d0_shamt), .funct(d0_funct),
    .offset(d0_offset), .instr_index(d0_instr_index), .cycle_1(d0_cycle_1),
    .cycle_2(d0_cycle_2), .active(d0_active)
  );

  int n_pass = 0;
  int n_fail = 0;

  // Reference model: phase 0=fetching, 1=first exec cycle, 2=second, 3=parked
  int          m_phase = 0;
  logic [31:0] m_ir  = '0;
  logic [31:0] m_ir0 = '0;

  function automatic logic [31:0] reverse_bytes(input logic [31:0] w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) r = (r << 8) | ((w >> (8 * b)) & 32'hFF);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_read, exp_c1, exp_c2, exp_act;
    exp_read = !reset && m_phase == 0;
    exp_c1   = !reset && m_phase == 1;
    exp_c2   = !reset && m_phase == 2;
    exp_act  = reset || m_phase != 3;
    check("mem_read", 32'(mem_read), 32'(exp_read));
    check("cycle_1", 32'(cycle_1), 32'(exp_c1));
    check("cycle_2", 32'(cycle_2), 32'(exp_c2));
    check("active", 32'(active), 32'(exp_act));
    check("d0_cycle_2", 32'(d0_cycle_2), 32'(exp_c2));
    if (exp_read) check("mem_address", mem_address, pc_address);
    check("instr", instr, m_ir);
    check("d0_instr", d0_instr, m_ir0);
    check("opcode", 32'(opcode), m_ir >> 26);
    check("rs", 32'(rs), (m_ir >> 21) & 32'h1F);
    check("branch_param", 32'(branch_param), (m_ir >> 16) & 32'h1F);
    check("rd", 32'(rd), (m_ir >> 11) & 32'h1F);
    check("shamt", 32'(shamt), (m_ir >> 6) & 32'h1F);
    check("funct", 32'(funct), m_ir & 32'h3F);
    check("offset", 32'(offset), m_ir & 32'hFFFF);
    check("instr_index", 32'(instr_index), m_ir & 32'h03FF_FFFF);
  endtask

  // One clock: check mid-cycle, advance model on the edge, move PC like the core would
  task automatic tick();
    int prev;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    prev = m_phase;
    if (reset) begin
      m_phase = 0;
      m_ir    = '0;
      m_ir0   = '0;
    end else if (m_phase == 0) begin
      if (!mem_waitrequest) begin
        m_ir    = reverse_bytes(mem_readdata);
        m_ir0   = mem_readdata;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!exec_stall) m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = halt ? 3 : 0;
    end
    #1;
    if (reset) pc_address = RV;
    else if (prev == 2) pc_address = pc_address + 32'd4;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset(2);
    check("rst_instr", instr, 32'h0);
    check("rst_active", 32'(active), 32'd1);

    // Zero-latency fetch of a JAL
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h0C00_0010;
    tick();
    check("t1_d0_instr", d0_instr, 32'h0C00_0010);
    check("t1_d0_opcode", 32'(d0_opcode), 32'd3);
    check("t1_d0_index", 32'(d0_instr_index), 32'h10);
    mem_waitrequest = 1'b1;
    tick();
    tick();

    // Waitrequest held three cycles, byte-swapped capture
    mem_readdata = 32'h7856_3412;
    for (int i = 0; i < 3; i++) tick();
    check("t2_no_capture", instr, 32'h1000_000C);
    mem_waitrequest = 1'b0;
    tick();
    check("t2_instr", instr, 32'h1234_5678);
    tick();
    tick();

    // Stall in EXEC1 for two cycles, stall also present in EXEC2
    mem_readdata = 32'h0123_4567;
    tick();
    exec_stall = 1'b1;
    tick();
    tick();
    exec_stall = 1'b0;
    tick();
    exec_stall = 1'b1;
    tick();
    check("t3_back_to_fetch", 32'(mem_read), 32'd1);
    exec_stall = 1'b0;

    // Halt seen only outside EXEC2 is ignored
    mem_readdata = 32'h8C22_0004;
    halt = 1'b1;
    tick();
    tick();
    halt = 1'b0;
    tick();
    tick();
    check("t6_no_halt", 32'(active), 32'd1);
    tick();
    tick();

    // Halt in EXEC2 parks the core until reset
    halt = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("t4_parked", 32'(active), 32'd0);
    halt = 1'b0;
    do_reset(1);
    check("t4_reset_instr", instr, 32'h0);

    // Reset during a stalled read; late data during reset is dropped
    mem_waitrequest = 1'b1;
    tick();
    tick();
    reset           = 1'b1;
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'hDEAD_BEEF;
    tick();
    reset           = 1'b0;
    mem_waitrequest = 1'b1;
    tick();
    check("t5_dropped", instr, 32'h0);
    mem_waitrequest = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 99) < 2) || (m_phase == 3 && $urandom_range(0, 9) == 0);
      mem_waitrequest = $urandom_range(0, 1) == 1;
      exec_stall      = $urandom_range(0, 2) == 0;
      halt            = $urandom_range(0, 15) == 0;
      mem_readdata    = $urandom;
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
